multicycle_main_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control decoder.

---
 rtl/multicycle_main_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Main control FSM for the multicycle MIPS datapath. It sequences fetch,
// decode, execute, memory and writeback over several cycles, and it drives
// the 2-bit ALU-op field consumed by the ALU control decoder plus every
// datapath enable.
// Memory states wait on i_memReady. They abort back to FETCH with an o_memErr
// pulse if memory stays silent for MEM_TIMEOUT cycles.
// Optional feature: define MULTICYCLE_ADDI_EN to add the ADDI_EXEC/ADDI_WB
// states. Without it, addi decodes as an illegal opcode.

module multicycle_main_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic [1:0] o_pcSource,
  output logic       o_iorD,
  output logic       o_memRead,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_memToReg,
  output logic       o_regWrite,
  output logic       o_regDst,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_aluOp,
  output logic [3:0] o_state,
  output logic       o_instrDone,
  output logic       o_illegal,
  output logic       o_memErr
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [3:0]      state;
  logic [3:0]      next_state;
  logic [TO_W-1:0] to_count;
  logic            in_mem_state;
  logic            timeout_hit;

  // Flags the states that issue a memory request and therefore wait on i_memReady
  always_comb begin
    in_mem_state = 1'b0;
    case (state)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: in_mem_state = 1'b1;
      default:                          in_mem_state = 1'b0;
    endcase
  end

  // Timeout fires only while memory is still not ready, so a ready that
  // arrives on the limit cycle wins and the normal transition is taken
  always_comb begin
    timeout_hit = (MEM_TIMEOUT != 0) && in_mem_state && !i_memReady &&
                  (to_count == TO_LIMIT);
  end

  // Next-state logic; opcode is decoded live from IR, which stays stable after FETCH
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (i_memReady)
          next_state = S_DECODE;
        else if (timeout_hit)
          next_state = S_FETCH;
      end
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      next_state = S_ADDI_EXEC;
`endif
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        next_state = (i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (i_memReady)
          next_state = S_MEM_WB;
        else if (timeout_hit)
          next_state = S_FETCH;
      end
      S_MEM_WB: next_state = S_FETCH;
      S_MEM_WRITE: begin
        if (i_memReady || timeout_hit)
          next_state = S_FETCH;
      end
      S_EXECUTE: next_state = S_R_WB;
      S_R_WB:    next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_ADDI_WB:   next_state = S_FETCH;
`endif
      default:   next_state = S_FETCH;
    endcase
  end

  // State register; a reset mid-instruction simply drops back to FETCH
  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= S_FETCH;
    else
      state <= next_state;
  end

  // Wait-cycle counter: cleared whenever a state is (re)entered, counts not-ready
  // cycles and parks at the limit so it never wraps
  always_ff @(posedge i_clk) begin
    if (i_rst)
      to_count <= '0;
    else if ((next_state != state) || timeout_hit)
      to_count <= '0;
    else if (in_mem_state && !i_memReady && (MEM_TIMEOUT != 0) &&
             (to_count != TO_LIMIT))
      to_count <= to_count + 1'b1;
  end

  // Moore decode of the control word; reset forces every output low
  always_comb begin
    o_pcWrite     = 1'b0;
    o_pcWriteCond = 1'b0;
    o_pcSource    = 2'b00;
    o_iorD        = 1'b0;
    o_memRead     = 1'b0;
    o_memWrite    = 1'b0;
    o_irWrite     = 1'b0;
    o_memToReg    = 1'b0;
    o_regWrite    = 1'b0;
    o_regDst      = 1'b0;
    o_aluSrcA     = 1'b0;
    o_aluSrcB     = 2'b00;
    o_aluOp       = 2'b00;
    o_instrDone   = 1'b0;
    o_illegal     = 1'b0;
    o_memErr      = 1'b0;
    o_state       = 4'd0;
    if (!i_rst) begin
      o_state  = state;
      o_memErr = timeout_hit;
      case (state)
        S_FETCH: begin
          o_memRead  = 1'b1;
          o_aluSrcB  = 2'b01;
          o_irWrite  = i_memReady;
          o_pcWrite  = i_memReady;
        end
        S_DECODE: begin
          o_aluSrcB = 2'b11;
          case (i_opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: o_illegal = 1'b0;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:                              o_illegal = 1'b0;
`endif
            default:                              o_illegal = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          o_aluSrcA = 1'b1;
          o_aluSrcB = 2'b10;
        end
        S_MEM_READ: begin
          o_memRead = 1'b1;
          o_iorD    = 1'b1;
        end
        S_MEM_WB: begin
          o_regWrite  = 1'b1;
          o_memToReg  = 1'b1;
          o_instrDone = 1'b1;
        end
        S_MEM_WRITE: begin
          o_memWrite  = 1'b1;
          o_iorD      = 1'b1;
          o_instrDone = i_memReady;
        end
        S_EXECUTE: begin
          o_aluSrcA = 1'b1;
          o_aluOp   = 2'b10;
        end
        S_R_WB: begin
          o_regWrite  = 1'b1;
          o_regDst    = 1'b1;
          o_instrDone = 1'b1;
        end
        S_BRANCH: begin
          o_aluSrcA     = 1'b1;
          o_aluOp       = 2'b01;
          o_pcWriteCond = 1'b1;
          o_pcSource    = 2'b01;
          o_instrDone   = 1'b1;
        end
        S_JUMP: begin
          o_pcWrite   = 1'b1;
          o_pcSource  = 2'b10;
          o_instrDone = 1'b1;
        end
`ifdef MULTICYCLE_ADDI_EN
        S_ADDI_EXEC: begin
          o_aluSrcA = 1'b1;
          o_aluSrcB = 2'b10;
        end
        S_ADDI_WB: begin
          o_regWrite  = 1'b1;
          o_instrDone = 1'b1;
        end
`endif
        default: o_state = state;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control
// Directed bench for the multicycle main control FSM. Inputs change on the
// falling clock edge and outputs are sampled 1 ns later, away from the rising
// edge where the FSM updates.
// The control word compared as "ctrl" packs the outputs as follows:
// {pcWrite, pcWriteCond, pcSource[1:0], iorD, memRead, memWrite, irWrite,
//  memToReg, regWrite, regDst, aluSrcA, aluSrcB[1:0], aluOp[1:0]}.
// The pulse word is {instrDone, illegal, memErr}.

module tb_multicycle_main_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;
  logic       instr_done, illegal, mem_err;

  int test_count = 0;
  int fail_count = 0;

  localparam logic [15:0] C_FETCH_RDY = 16'b1000_0101_0000_0100;
  localparam logic [15:0] C_FETCH_NR  = 16'b0000_0100_0000_0100;
  localparam logic [15:0] C_DECODE    = 16'b0000_0000_0000_1100;
  localparam logic [15:0] C_MEM_ADDR  = 16'b0000_0000_0001_1000;
  localparam logic [15:0] C_MEM_READ  = 16'b0000_1100_0000_0000;
  localparam logic [15:0] C_MEM_WB    = 16'b0000_0000_1100_0000;
  localparam logic [15:0] C_MEM_WRITE = 16'b0000_1010_0000_0000;
  localparam logic [15:0] C_EXECUTE   = 16'b0000_0000_0001_0010;
  localparam logic [15:0] C_R_WB      = 16'b0000_0000_0110_0000;
  localparam logic [15:0] C_BRANCH    = 16'b0101_0000_0001_0001;
  localparam logic [15:0] C_JUMP      = 16'b1010_0000_0000_0000;
  localparam logic [15:0] C_ADDI_WB   = 16'b0000_0000_0100_0000;

  multicycle_main_control dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_opcode      (opcode),
    .i_memReady    (mem_ready),
    .o_pcWrite     (pc_write),
    .o_pcWriteCond (pc_write_cond),
    .o_pcSource    (pc_source),
    .o_iorD        (ior_d),
    .o_memRead     (mem_read),
    .o_memWrite    (mem_write),
    .o_irWrite     (ir_write),
    .o_memToReg    (mem_to_reg),
    .o_regWrite    (reg_write),
    .o_regDst      (reg_dst),
    .o_aluSrcA     (alu_src_a),
    .o_aluSrcB     (alu_src_b),
    .o_aluOp       (alu_op),
    .o_state       (state),
    .o_instrDone   (instr_done),
    .o_illegal     (illegal),
    .o_memErr      (mem_err)
  );

  logic [15:0] ctrl;
  logic [2:0]  pulses;
  assign ctrl   = {pc_write, pc_write_cond, pc_source, ior_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op};
  assign pulses = {instr_done, illegal, mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and tallies the result
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge, then lets outputs settle
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  // Checks state, control word and pulses for the current cycle
  task automatic expectCycle(input string tag, input logic [3:0] st, input logic [15:0] c,
                             input logic [2:0] p);
    checkOutput({tag, "_state"}, 32'(state), 32'(st));
    checkOutput({tag, "_ctrl"}, 32'(ctrl), 32'(c));
    checkOutput({tag, "_pulse"}, 32'(pulses), 32'(p));
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 6'b000000, 1'b1);
      expectCycle("reset", 4'd0, 16'h0000, 3'b000);
    end

    // R-type: 0,1,6,7,0
    applyStimulus(1'b0, 6'b000000, 1'b1);
    expectCycle("rt_fetch", 4'd0, C_FETCH_RDY, 3'b000);
    applyStimulus(1'b0, 6'b000000, 1'b1);
    expectCycle("rt_decode", 4'd1, C_DECODE, 3'b000);
    applyStimulus(1'b0, 6'b000000, 1'b1);
    expectCycle("rt_exec", 4'd6, C_EXECUTE, 3'b000);
    applyStimulus(1'b0, 6'b000000, 1'b1);
    expectCycle("rt_wb", 4'd7, C_R_WB, 3'b100);

    // lw with three not-ready cycles in MEM_READ
    applyStimulus(1'b0, 6'b100011, 1'b1);
    expectCycle("lw_fetch", 4'd0, C_FETCH_RDY, 3'b000);
    applyStimulus(1'b0, 6'b100011, 1'b1);
    expectCycle("lw_decode", 4'd1, C_DECODE, 3'b000);
    applyStimulus(1'b0, 6'b100011, 1'b1);
    expectCycle("lw_addr", 4'd2, C_MEM_ADDR, 3'b000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'b100011, 1'b0);
      expectCycle("lw_wait", 4'd3, C_MEM_READ, 3'b000);
    end
    applyStimulus(1'b0, 6'b100011, 1'b1);
    expectCycle("lw_read", 4'd3, C_MEM_READ, 3'b000);
    applyStimulus(1'b0, 6'b100011, 1'b1);
    expectCycle("lw_wb", 4'd4, C_MEM_WB, 3'b100);

    // sw with memory stuck not-ready: error on the 16th MEM_WRITE cycle
    applyStimulus(1'b0, 6'b101011, 1'b1);
    expectCycle("sw_fetch", 4'd0, C_FETCH_RDY, 3'b000);
    applyStimulus(1'b0, 6'b101011, 1'b1);
    expectCycle("sw_decode", 4'd1, C_DECODE, 3'b000);
    applyStimulus(1'b0, 6'b101011, 1'b1);
    expectCycle("sw_addr", 4'd2, C_MEM_ADDR, 3'b000);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 6'b101011, 1'b0);
      expectCycle("sw_wait", 4'd5, C_MEM_WRITE, 3'b000);
    end
    applyStimulus(1'b0, 6'b101011, 1'b0);
    expectCycle("sw_timeout", 4'd5, C_MEM_WRITE, 3'b001);

    // Refetch with ready only on the limit cycle: ready wins, no error
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 6'b000100, 1'b0);
      expectCycle("fetch_wait", 4'd0, C_FETCH_NR, 3'b000);
    end
    applyStimulus(1'b0, 6'b000100, 1'b1);
    expectCycle("fetch_limit_rdy", 4'd0, C_FETCH_RDY, 3'b000);

    // beq
    applyStimulus(1'b0, 6'b000100, 1'b1);
    expectCycle("beq_decode", 4'd1, C_DECODE, 3'b000);
    applyStimulus(1'b0, 6'b000100, 1'b1);
    expectCycle("beq_branch", 4'd8, C_BRANCH, 3'b100);

    // j
    applyStimulus(1'b0, 6'b000010, 1'b1);
    expectCycle("j_fetch", 4'd0, C_FETCH_RDY, 3'b000);
    applyStimulus(1'b0, 6'b000010, 1'b1);
    expectCycle("j_decode", 4'd1, C_DECODE, 3'b000);
    applyStimulus(1'b0, 6'b000010, 1'b1);
    expectCycle("j_jump", 4'd9, C_JUMP, 3'b100);

    // addi
    applyStimulus(1'b0, 6'b001000, 1'b1);
    expectCycle("addi_fetch", 4'd0, C_FETCH_RDY, 3'b000);
`ifdef MULTICYCLE_ADDI_EN
    applyStimulus(1'b0, 6'b001000, 1'b1);
    expectCycle("addi_decode", 4'd1, C_DECODE, 3'b000);
    applyStimulus(1'b0, 6'b001000, 1'b1);
    expectCycle("addi_exec", 4'd10, C_MEM_ADDR, 3'b000);
    applyStimulus(1'b0, 6'b001000, 1'b1);
    expectCycle("addi_wb", 4'd11, C_ADDI_WB, 3'b100);
`else
    applyStimulus(1'b0, 6'b001000, 1'b1);
    expectCycle("addi_illegal", 4'd1, C_DECODE, 3'b010);
`endif

    // Unsupported opcode
    applyStimulus(1'b0, 6'b111111, 1'b1);
    expectCycle("ill_fetch", 4'd0, C_FETCH_RDY, 3'b000);
    applyStimulus(1'b0, 6'b111111, 1'b1);
    expectCycle("ill_decode", 4'd1, C_DECODE, 3'b010);

    // Reset in the middle of an R-type discards it
    applyStimulus(1'b0, 6'b000000, 1'b1);
    expectCycle("mid_fetch", 4'd0, C_FETCH_RDY, 3'b000);
    applyStimulus(1'b0, 6'b000000, 1'b1);
    expectCycle("mid_decode", 4'd1, C_DECODE, 3'b000);
    applyStimulus(1'b0, 6'b000000, 1'b1);
    expectCycle("mid_exec", 4'd6, C_EXECUTE, 3'b000);
    applyStimulus(1'b1, 6'b000000, 1'b1);
    expectCycle("mid_reset", 4'd0, 16'h0000, 3'b000);
    applyStimulus(1'b0, 6'b000000, 1'b1);
    expectCycle("mid_refetch", 4'd0, C_FETCH_RDY, 3'b000);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
